// File: rtl/ap_host_seq.sv
// ap_host_seq: host-side sequencer that loads A/B operand columns into the AP core,
// runs one pass and streams column C back. Define AP_HOST_TIMEOUT_EN to add a RUN-state watchdog.
module ap_host_seq #(
  parameter int WORD_SIZE      = 8,
  parameter int CELL_QUANT     = 512,
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      len,
  input  logic [2:0]           op,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ap_rst,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WRITE, S_HOLD, S_RUN, S_READ, S_EMIT, S_DONE
  } state_t;

  localparam logic [1:0] COL_A = 2'd0;
  localparam logic [1:0] COL_B = 2'd1;
  localparam logic [1:0] COL_C = 2'd2;

  // One shared counter serves the CLEAR pulse, the read latency and the RUN watchdog.
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RD_W  = $clog2(RD_LAT + 1);
  localparam int MAX_W = (TMO_W > RD_W) ? TMO_W : RD_W;
  localparam int CNT_W = (MAX_W > 2) ? MAX_W : 2;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(CELL_QUANT);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W:0]        r_idx;
  logic [ADDR_W:0]        r_len;
  logic [1:0]             r_col;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [WORD_SIZE-1:0]   r_out_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_ap_rst;
  logic                   r_ap_mode;
  logic [2:0]             r_ap_cmd;
  logic [ADDR_W-1:0]      r_ap_addr;
  logic [WORD_SIZE-1:0]   r_ap_data;
  logic [1:0]             r_ap_sel_col;
  logic                   r_ap_write_en;
  logic                   r_ap_read_en;

  logic                   w_len_ok;
  logic [ADDR_W:0]        w_idx_inc;

  assign w_len_ok  = (len != '0) && (len <= LEN_MAX);
  assign w_idx_inc = r_idx + 1'b1;

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_col         <= COL_A;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_ap_rst      <= 1'b1;
      r_ap_mode     <= 1'b0;
      r_ap_cmd      <= '0;
      r_ap_addr     <= '0;
      r_ap_data     <= '0;
      r_ap_sel_col  <= COL_A;
      r_ap_write_en <= 1'b0;
      r_ap_read_en  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ap_rst <= 1'b0;
          if (start) begin
            if (w_len_ok) begin
              r_len    <= len;
              r_ap_cmd <= op;
              r_err    <= 1'b0;
              r_ap_rst <= 1'b1;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_CLEAR;
            end else begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end

        // ap_rst was raised on entry; it stays high for this cycle and the next.
        S_CLEAR: begin
          if (r_cnt == CNT_W'(1)) begin
            r_ap_rst   <= 1'b0;
            r_idx      <= '0;
            r_col      <= COL_A;
            r_in_ready <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_FETCH: begin
          if (in_valid && r_in_ready) begin
            r_in_ready    <= 1'b0;
            r_ap_data     <= in_data;
            r_ap_addr     <= r_idx[ADDR_W-1:0];
            r_ap_sel_col  <= r_col;
            r_ap_write_en <= 1'b1;
            r_state       <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_ap_write_en <= 1'b0;
          r_state       <= S_HOLD;
        end

        // The AP samples its write strobe a cycle late, so address/column/data stay put here.
        S_HOLD: begin
          if (r_col == COL_A) begin
            r_col      <= COL_B;
            r_in_ready <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_col <= COL_A;
            r_idx <= w_idx_inc;
            if (w_idx_inc == r_len) begin
              r_ap_mode <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_RUN;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end

        S_RUN: begin
          if (ap_irq) begin
            r_ap_mode    <= 1'b0;
            r_idx        <= '0;
            r_ap_addr    <= '0;
            r_ap_sel_col <= COL_C;
            r_ap_read_en <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_READ;
          end
`ifdef AP_HOST_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_err     <= 1'b1;
            r_ap_mode <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        // Strobe covers RD_LAT cycles; data is valid in the cycle after the strobe drops.
        S_READ: begin
          if (r_cnt == CNT_W'(RD_LAT - 1)) begin
            r_ap_read_en <= 1'b0;
          end
          if (r_cnt == CNT_W'(RD_LAT)) begin
            r_out_data  <= ap_data_out;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= w_idx_inc;
            if (w_idx_inc == r_len) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ap_addr    <= w_idx_inc[ADDR_W-1:0];
              r_ap_read_en <= 1'b1;
              r_cnt        <= '0;
              r_state      <= S_READ;
            end
          end
        end

        S_DONE: begin
          r_ap_mode <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign ap_rst      = r_ap_rst;
  assign ap_mode     = r_ap_mode;
  assign ap_cmd      = r_ap_cmd;
  assign ap_addr     = r_ap_addr;
  assign ap_data     = r_ap_data;
  assign ap_sel_col  = r_ap_sel_col;
  assign ap_write_en = r_ap_write_en;
  assign ap_read_en  = r_ap_read_en;

endmodule
